// File: rtl/freq_period_meter.sv
// Period / high-time meter for slow periodic inputs sampled in the clk domain.
// Reports rise-to-rise and rise-to-fall spacing, lock on stable period, stall timeout.
module freq_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_CNT);
    localparam logic [MW-1:0] M_ONE = MW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_s;
    logic                   rise_det;
    logic                   fall_det;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_pend_q;
    logic [MW-1:0]    match_q;
    logic [MW-1:0]    match_d;
    logic             tmo_hit;
    logic             meas_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign rise_det = sync_s & ~hist_q;
    assign fall_det = ~sync_s & hist_q;

    // Counter value in a cycle equals cycles elapsed since the last rise.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    assign tmo_hit  = (cnt_q == CNT_MAX - CNT_ONE);
    assign meas_evt = en && (state_q == MEASURE) && rise_det;

    always_comb begin
        match_d = M_ONE;
        if (match_q != '0 && cnt_q == period) begin
            match_d = (match_q == LOCK_N) ? LOCK_N : match_q + M_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = ARM;
            end
            ARM: begin
                if (!en) state_d = IDLE;
                else if (rise_det) state_d = MEASURE;
            end
            MEASURE: begin
                if (!en) state_d = IDLE;
                else if (!rise_det && tmo_hit) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            high_pend_q <= '0;
            match_q     <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= meas_evt;
            if (!en) begin
                cnt_q       <= '0;
                high_pend_q <= '0;
                match_q     <= '0;
                locked      <= 1'b0;
                timeout     <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        cnt_q       <= '0;
                        high_pend_q <= '0;
                    end
                    ARM: begin
                        if (rise_det) begin
                            cnt_q       <= CNT_ONE;
                            high_pend_q <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (tmo_hit) begin
                                timeout <= 1'b1;
                                locked  <= 1'b0;
                                match_q <= '0;
                            end
                        end
                    end
                    MEASURE: begin
                        if (rise_det) begin
                            period      <= cnt_q;
                            high_time   <= high_pend_q;
                            high_pend_q <= '0;
                            cnt_q       <= CNT_ONE;
                            timeout     <= 1'b0;
                            match_q     <= match_d;
                            locked      <= (match_d == LOCK_N);
                        end else begin
                            cnt_q <= cnt_inc;
                            if (tmo_hit) begin
                                timeout <= 1'b1;
                                locked  <= 1'b0;
                                match_q <= '0;
                            end else if (fall_det) begin
                                high_pend_q <= cnt_q;
                            end
                        end
                    end
                    default: begin
                        cnt_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule
